// File: rtl/y86_pkg.sv
// ----------------------------------------------------------------------------
// y86_pkg
// Shared constants for the Y86-64 pipeline controller: instruction codes,
// status codes, the "no register" marker and the sequencer state encoding.
// Also provides is_exc(), the test for a status that stops the machine.
// ----------------------------------------------------------------------------
package y86_pkg;

    // Instruction codes
    localparam logic [3:0] I_HALT   = 4'd0;
    localparam logic [3:0] I_NOP    = 4'd1;
    localparam logic [3:0] I_RRMOVQ = 4'd2;
    localparam logic [3:0] I_IRMOVQ = 4'd3;
    localparam logic [3:0] I_RMMOVQ = 4'd4;
    localparam logic [3:0] I_MRMOVQ = 4'd5;
    localparam logic [3:0] I_OPQ    = 4'd6;
    localparam logic [3:0] I_JXX    = 4'd7;
    localparam logic [3:0] I_CALL   = 4'd8;
    localparam logic [3:0] I_RET    = 4'd9;
    localparam logic [3:0] I_PUSHQ  = 4'd10;
    localparam logic [3:0] I_POPQ   = 4'd11;

    // Status codes
    localparam logic [2:0] S_AOK = 3'd1;
    localparam logic [2:0] S_HLT = 3'd2;
    localparam logic [2:0] S_ADR = 3'd3;
    localparam logic [2:0] S_INS = 3'd4;

    // Register id meaning "no register"
    localparam logic [3:0] RNONE = 4'hF;

    // Sequencer state encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    // True for any status that stops the machine
    function automatic logic is_exc(input logic [2:0] s);
        return (s == S_HLT) || (s == S_ADR) || (s == S_INS);
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// ----------------------------------------------------------------------------
// pipe_ctrl_if
// Bundle between the pipeline stages and the pipeline controller.
//   Pipeline -> controller: start, f_predPC, D_icode, d_srcA, d_srcB, E_icode,
//                           E_dstM, e_Cnd, M_icode, m_stat, W_icode, W_stat
//   Controller -> pipeline: F_predPC, F_stall, D_stall, D_bubble, E_bubble,
//                           M_bubble, W_stall, set_cc, cpu_stat
// Modport master is the controller side, slave is the pipeline side.
// ----------------------------------------------------------------------------
interface pipe_ctrl_if;

    logic        start;
    logic [63:0] f_predPC;
    logic [3:0]  D_icode;
    logic [3:0]  d_srcA;
    logic [3:0]  d_srcB;
    logic [3:0]  E_icode;
    logic [3:0]  E_dstM;
    logic        e_Cnd;
    logic [3:0]  M_icode;
    logic [2:0]  m_stat;
    logic [3:0]  W_icode;
    logic [2:0]  W_stat;

    logic [63:0] F_predPC;
    logic        F_stall;
    logic        D_stall;
    logic        D_bubble;
    logic        E_bubble;
    logic        M_bubble;
    logic        W_stall;
    logic        set_cc;
    logic [2:0]  cpu_stat;

    modport master (
        input  start, f_predPC, D_icode, d_srcA, d_srcB, E_icode, E_dstM,
               e_Cnd, M_icode, m_stat, W_icode, W_stat,
        output F_predPC, F_stall, D_stall, D_bubble, E_bubble, M_bubble,
               W_stall, set_cc, cpu_stat
    );

    modport slave (
        output start, f_predPC, D_icode, d_srcA, d_srcB, E_icode, E_dstM,
               e_Cnd, M_icode, m_stat, W_icode, W_stat,
        input  F_predPC, F_stall, D_stall, D_bubble, E_bubble, M_bubble,
               W_stall, set_cc, cpu_stat
    );

endinterface

// File: rtl/pipe_ctrl_hazard.sv
// ----------------------------------------------------------------------------
// hazard_unit
// Purely combinational hazard detection giving the RUN-mode stall/bubble
// controls. Inputs are the decode/execute/memory/writeback fields that
// matter for load-use, return and mispredict hazards plus the stage
// statuses; outputs are the per-stage stall/bubble and the CC enable.
// ----------------------------------------------------------------------------
module hazard_unit
    import y86_pkg::*;
(
    input  logic [3:0] D_icode,
    input  logic [3:0] d_srcA,
    input  logic [3:0] d_srcB,
    input  logic [3:0] E_icode,
    input  logic [3:0] E_dstM,
    input  logic       e_Cnd,
    input  logic [3:0] M_icode,
    input  logic [2:0] m_stat,
    input  logic [2:0] W_stat,
    output logic       F_stall,
    output logic       D_stall,
    output logic       D_bubble,
    output logic       E_bubble,
    output logic       M_bubble,
    output logic       W_stall,
    output logic       set_cc
);

    logic lu, rt, mp, m_exc, w_exc;

    always_comb begin
        lu    = ((E_icode == I_MRMOVQ) || (E_icode == I_POPQ)) &&
                (E_dstM != RNONE) &&
                ((E_dstM == d_srcA) || (E_dstM == d_srcB));
        rt    = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
        mp    = (E_icode == I_JXX) && !e_Cnd;
        m_exc = is_exc(m_stat);
        w_exc = is_exc(W_stat);

        F_stall  = lu || rt;
        D_stall  = lu;
        // A load-use stall must hold D, so it suppresses the return bubble
        D_bubble = mp || (!lu && rt);
        E_bubble = mp || lu;
        M_bubble = m_exc || w_exc;
        W_stall  = w_exc;
        set_cc   = (E_icode == I_OPQ) && !m_exc && !w_exc;
    end

endmodule

// File: rtl/pipe_ctrl.sv
// ----------------------------------------------------------------------------
// pipe_ctrl
// Pipeline controller for the 5-stage Y86-64 core. Owns the F register
// (F_predPC), runs the IDLE/RUN/HALT sequencer, overrides the hazard
// controls outside RUN so the pipe stays frozen, and keeps run statistics.
// Ports:
//   clk, rst   rising-edge clock, synchronous active-high reset
//   bus        pipe_ctrl_if.master: hazard inputs in, stage controls out
//   state      sequencer state (IDLE=0, RUN=1, HALT=2)
//   cycle_cnt  RUN cycles; instr_cnt retired instructions;
//   stall_cnt  RUN cycles with F stalled (all wrap)
// ----------------------------------------------------------------------------
module pipe_ctrl
    import y86_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    pipe_ctrl_if.master      bus,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    logic h_F_stall, h_D_stall, h_D_bubble, h_E_bubble;
    logic h_M_bubble, h_W_stall, h_set_cc;
    logic run;

    hazard_unit u_hazard (
        .D_icode  (bus.D_icode),
        .d_srcA   (bus.d_srcA),
        .d_srcB   (bus.d_srcB),
        .E_icode  (bus.E_icode),
        .E_dstM   (bus.E_dstM),
        .e_Cnd    (bus.e_Cnd),
        .M_icode  (bus.M_icode),
        .m_stat   (bus.m_stat),
        .W_stat   (bus.W_stat),
        .F_stall  (h_F_stall),
        .D_stall  (h_D_stall),
        .D_bubble (h_D_bubble),
        .E_bubble (h_E_bubble),
        .M_bubble (h_M_bubble),
        .W_stall  (h_W_stall),
        .set_cc   (h_set_cc)
    );

    assign run = (state == ST_RUN);

    // Outside RUN every stage is held or flushed so nothing advances
    always_comb begin
        bus.F_stall  = run ? h_F_stall  : 1'b1;
        bus.D_stall  = run ? h_D_stall  : 1'b0;
        bus.D_bubble = run ? h_D_bubble : 1'b1;
        bus.E_bubble = run ? h_E_bubble : 1'b1;
        bus.M_bubble = run ? h_M_bubble : 1'b1;
        bus.W_stall  = run ? h_W_stall  : 1'b1;
        bus.set_cc   = run ? h_set_cc   : 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            bus.F_predPC <= RESET_PC;
            bus.cpu_stat <= S_AOK;
            cycle_cnt    <= '0;
            instr_cnt    <= '0;
            stall_cnt    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    cycle_cnt <= cycle_cnt + 1'b1;
                    if (bus.F_stall) begin
                        stall_cnt <= stall_cnt + 1'b1;
                    end
                    if ((bus.W_stat == S_AOK) && (bus.W_icode != I_NOP)) begin
                        instr_cnt <= instr_cnt + 1'b1;
                    end
                    if (!bus.F_stall) begin
                        bus.F_predPC <= bus.f_predPC;
                    end
                    if (bus.W_stat != S_AOK) begin
                        state        <= ST_HALT;
                        bus.cpu_stat <= bus.W_stat;
                    end
                end
                default: begin
                    // HALT (and any unused encoding) holds until reset
                end
            endcase
        end
    end

endmodule
